// File: rtl/cpu6_pkg.sv
// Shared definitions for the cpu6 core: opcodes, FSM states, register byte indices,
// the logical-to-physical address map and per-opcode operand/data byte counts.
package cpu6_pkg;

    typedef enum logic [2:0] {FETCH, OPERAND, MEMRD, MEMWR, EXEC, HALT} state_t;
    typedef enum logic [2:0] {ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_SHL} alu_op_t;

    localparam logic [7:0] OP_HLT    = 8'h00;
    localparam logic [7:0] OP_NOP    = 8'h01;
    localparam logic [7:0] OP_EI     = 8'h04;
    localparam logic [7:0] OP_DI     = 8'h05;
    localparam logic [7:0] OP_RETI   = 8'h0A;
    localparam logic [7:0] OP_BZ     = 8'h14;
    localparam logic [7:0] OP_BNZ    = 8'h15;
    localparam logic [7:0] OP_CLR    = 8'h22;
    localparam logic [7:0] OP_CLAW   = 8'h3A;
    localparam logic [7:0] OP_SLAW   = 8'h3D;
    localparam logic [7:0] OP_ADD    = 8'h40;
    localparam logic [7:0] OP_AND    = 8'h42;
    localparam logic [7:0] OP_SABL   = 8'h49;
    localparam logic [7:0] OP_AABW   = 8'h58;
    localparam logic [7:0] OP_XASW   = 8'h5F;
    localparam logic [7:0] OP_JMP    = 8'h71;
    localparam logic [7:0] OP_LDAL_I = 8'h80;
    localparam logic [7:0] OP_LDAL_M = 8'h81;
    localparam logic [7:0] OP_LDAW_I = 8'h90;
    localparam logic [7:0] OP_LDAW_M = 8'h91;
    localparam logic [7:0] OP_STAL   = 8'hA1;
    localparam logic [7:0] OP_STAW   = 8'hB1;
    localparam logic [7:0] OP_LDBL_I = 8'hC0;
    localparam logic [7:0] OP_LDBL_M = 8'hC1;

    localparam logic [2:0] R_AH = 3'd0;
    localparam logic [2:0] R_AL = 3'd1;
    localparam logic [2:0] R_BH = 3'd2;
    localparam logic [2:0] R_BL = 3'd3;
    localparam logic [2:0] R_XH = 3'd4;
    localparam logic [2:0] R_XL = 3'd5;
    localparam logic [2:0] R_SH = 3'd6;
    localparam logic [2:0] R_SL = 3'd7;

    localparam logic [2:0]  IO_PAGE    = 3'b011;
    localparam logic [15:0] RESET_PC   = 16'hFD00;
    localparam logic [15:0] IRQ_VECTOR = 16'h0100;

    // The top 4 KB of logical space is the IO page.
    function automatic logic [18:0] map_addr(input logic [15:0] l);
        return (l[15:12] == 4'hF) ? {IO_PAGE, l} : {3'b000, l};
    endfunction

    function automatic logic [1:0] operand_bytes(input logic [7:0] op);
        case (op)
            OP_BZ, OP_BNZ, OP_CLR, OP_ADD, OP_AND, OP_LDAL_I, OP_LDBL_I: return 2'd1;
            OP_JMP, OP_LDAL_M, OP_LDAW_I, OP_LDAW_M, OP_LDBL_M,
            OP_STAL, OP_STAW:                                             return 2'd2;
            default:                                                      return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] data_bytes(input logic [7:0] op);
        case (op)
            OP_LDAL_M, OP_LDBL_M, OP_STAL: return 2'd1;
            OP_LDAW_M, OP_STAW:            return 2'd2;
            default:                       return 2'd0;
        endcase
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == OP_STAL) || (op == OP_STAW);
    endfunction

endpackage

// File: rtl/cpu6_alu.sv
// Combinational ALU for cpu6: pass/add/sub/and/shift-left in 8- or 16-bit width,
// with zero, negative and carry/borrow outputs.
module cpu6_alu
    import cpu6_pkg::*;
(
    input  alu_op_t     op,
    input  logic        wide,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result,
    output logic        z,
    output logic        n,
    output logic        c
);

    logic [16:0] ext;

    // Byte operations place their carry in bit 8 of ext; word operations in bit 16.
    always_comb begin
        ext = {1'b0, b};
        case (op)
            ALU_ADD: ext = wide ? ({1'b0, a} + {1'b0, b})
                                : {8'h00, ({1'b0, a[7:0]} + {1'b0, b[7:0]})};
            ALU_SUB: ext = wide ? ({1'b0, a} - {1'b0, b})
                                : {8'h00, ({1'b0, a[7:0]} - {1'b0, b[7:0]})};
            ALU_AND: ext = {1'b0, a & b};
            ALU_SHL: ext = wide ? {a, 1'b0} : {8'h00, a[7:0], 1'b0};
            default: ext = {1'b0, b};
        endcase
        result = wide ? ext[15:0] : {8'h00, ext[7:0]};
        z      = wide ? (result == 16'h0000) : (result[7:0] == 8'h00);
        n      = wide ? result[15] : result[7];
        c      = wide ? ext[16] : ext[8];
    end

endmodule

// File: rtl/cpu6.sv
// Multi-cycle 8-bit CPU6-subset core on a single byte-wide bus.
// Define CPU6_TRACE_EN to print PC and opcode on every fetch in simulation.
module cpu6
    import cpu6_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        int_reqn,
    output logic [3:0]  irq_number,
    output logic        write_en,
    output logic [18:0] address,
    output logic [7:0]  data_out
);

    state_t      state;
    logic [7:0]  opcode;
    logic [15:0] opr, dat, pc, rpc;
    logic        cnt, flag_z, flag_n, flag_c, ie;
    logic [7:0]  rf [8];

    logic [15:0] reg_a, reg_b, bus_logical, pc_next;
    logic        last_opr, last_dat;

    alu_op_t     alu_op;
    logic        alu_wide, alu_z, alu_n, alu_c;
    logic [15:0] alu_a, alu_b, alu_res;
    logic        wr_en, wr_wide, set_zn, set_c, ie_next, go_halt, take_irq;
    logic [2:0]  wr_idx;
    logic [3:0]  irq_next;

    assign reg_a    = {rf[R_AH], rf[R_AL]};
    assign reg_b    = {rf[R_BH], rf[R_BL]};
    assign last_opr = ({1'b0, cnt} == operand_bytes(opcode) - 2'd1);
    assign last_dat = ({1'b0, cnt} == data_bytes(opcode) - 2'd1);

    assign bus_logical = (state == MEMRD || state == MEMWR) ? opr + {15'd0, cnt} : pc;
    assign address     = map_addr(bus_logical);
    assign write_en    = (state == MEMWR);
    assign data_out    = !write_en ? 8'h00 :
                         (opcode == OP_STAW && !cnt) ? rf[R_AH] : rf[R_AL];

    cpu6_alu alu (
        .op     (alu_op),
        .wide   (alu_wide),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_res),
        .z      (alu_z),
        .n      (alu_n),
        .c      (alu_c)
    );

    // Execute-stage decode; undefined opcodes fall into the halt path.
    always_comb begin
        alu_op   = ALU_PASS;
        alu_wide = 1'b0;
        alu_a    = reg_a;
        alu_b    = 16'h0000;
        wr_en    = 1'b0;
        wr_wide  = 1'b0;
        wr_idx   = R_AL;
        set_zn   = 1'b0;
        set_c    = 1'b0;
        pc_next  = pc;
        ie_next  = ie;
        irq_next = irq_number;
        go_halt  = 1'b0;
        case (opcode)
            OP_NOP, OP_STAL, OP_STAW: ;
            OP_EI:   ie_next = 1'b1;
            OP_DI:   ie_next = 1'b0;
            OP_RETI: begin pc_next = rpc; ie_next = 1'b1; irq_next = 4'd0; end
            OP_BZ:   if (flag_z)  pc_next = pc + {{8{opr[7]}}, opr[7:0]};
            OP_BNZ:  if (!flag_z) pc_next = pc + {{8{opr[7]}}, opr[7:0]};
            OP_JMP:  pc_next = opr;
            OP_CLR:  begin wr_en = 1'b1; wr_idx = opr[6:4]; set_zn = 1'b1; end
            OP_CLAW: begin alu_wide = 1'b1; wr_en = 1'b1; wr_wide = 1'b1; wr_idx = R_AH; set_zn = 1'b1; end
            OP_SLAW: begin
                alu_op = ALU_SHL; alu_wide = 1'b1;
                wr_en = 1'b1; wr_wide = 1'b1; wr_idx = R_AH; set_zn = 1'b1; set_c = 1'b1;
            end
            OP_ADD, OP_AND: begin
                alu_op = (opcode == OP_ADD) ? ALU_ADD : ALU_AND;
                alu_a  = {8'h00, rf[opr[2:0]]};
                alu_b  = {8'h00, rf[opr[6:4]]};
                wr_en  = 1'b1; wr_idx = opr[2:0]; set_zn = 1'b1; set_c = (opcode == OP_ADD);
            end
            OP_SABL: begin
                alu_op = ALU_SUB; alu_a = {8'h00, rf[R_AL]}; alu_b = {8'h00, rf[R_BL]};
                wr_en = 1'b1; set_zn = 1'b1; set_c = 1'b1;
            end
            OP_AABW: begin
                alu_op = ALU_ADD; alu_wide = 1'b1; alu_b = reg_b;
                wr_en = 1'b1; wr_wide = 1'b1; wr_idx = R_AH; set_zn = 1'b1; set_c = 1'b1;
            end
            OP_XASW:   begin alu_wide = 1'b1; alu_b = reg_a; wr_en = 1'b1; wr_wide = 1'b1; wr_idx = R_SH; set_zn = 1'b1; end
            OP_LDAL_I: begin alu_b = {8'h00, opr[7:0]}; wr_en = 1'b1; set_zn = 1'b1; end
            OP_LDAL_M: begin alu_b = {8'h00, dat[7:0]}; wr_en = 1'b1; set_zn = 1'b1; end
            OP_LDAW_I: begin alu_wide = 1'b1; alu_b = opr; wr_en = 1'b1; wr_wide = 1'b1; wr_idx = R_AH; set_zn = 1'b1; end
            OP_LDAW_M: begin alu_wide = 1'b1; alu_b = dat; wr_en = 1'b1; wr_wide = 1'b1; wr_idx = R_AH; set_zn = 1'b1; end
            OP_LDBL_I: begin alu_b = {8'h00, opr[7:0]}; wr_en = 1'b1; wr_idx = R_BL; set_zn = 1'b1; end
            OP_LDBL_M: begin alu_b = {8'h00, dat[7:0]}; wr_en = 1'b1; wr_idx = R_BL; set_zn = 1'b1; end
            default:   go_halt = 1'b1;
        endcase
        take_irq = !go_halt && ie_next && !int_reqn;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            rpc        <= 16'h0000;
            opcode     <= 8'h00;
            opr        <= 16'h0000;
            dat        <= 16'h0000;
            cnt        <= 1'b0;
            flag_z     <= 1'b0;
            flag_n     <= 1'b0;
            flag_c     <= 1'b0;
            ie         <= 1'b0;
            irq_number <= 4'd0;
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        end else begin
            case (state)
                FETCH: begin
                    opcode <= data_in;
                    pc     <= pc + 16'd1;
                    cnt    <= 1'b0;
                    state  <= (operand_bytes(data_in) != 2'd0) ? OPERAND : EXEC;
                end
                OPERAND: begin
                    opr <= {opr[7:0], data_in};
                    pc  <= pc + 16'd1;
                    if (last_opr) begin
                        cnt <= 1'b0;
                        if (data_bytes(opcode) == 2'd0) state <= EXEC;
                        else if (is_store(opcode))      state <= MEMWR;
                        else                            state <= MEMRD;
                    end else begin
                        cnt <= 1'b1;
                    end
                end
                MEMRD: begin
                    dat <= {dat[7:0], data_in};
                    if (last_dat) begin cnt <= 1'b0; state <= EXEC; end
                    else          cnt <= 1'b1;
                end
                MEMWR: begin
                    if (last_dat) begin cnt <= 1'b0; state <= EXEC; end
                    else          cnt <= 1'b1;
                end
                EXEC: begin
                    if (wr_en) begin
                        if (wr_wide) begin
                            rf[wr_idx]                <= alu_res[15:8];
                            rf[{wr_idx[2:1], 1'b1}]   <= alu_res[7:0];
                        end else begin
                            rf[wr_idx] <= alu_res[7:0];
                        end
                    end
                    if (set_zn) begin flag_z <= alu_z; flag_n <= alu_n; end
                    if (set_c)  flag_c <= alu_c;
                    ie         <= ie_next;
                    irq_number <= irq_next;
                    if (go_halt) begin
                        state <= HALT;
                    end else if (take_irq) begin
                        rpc        <= pc_next;
                        pc         <= IRQ_VECTOR;
                        ie         <= 1'b0;
                        irq_number <= 4'd1;
                        state      <= FETCH;
                    end else begin
                        pc    <= pc_next;
                        state <= FETCH;
                    end
                end
                HALT:    state <= HALT;
                default: state <= HALT;
            endcase
        end
    end

`ifdef CPU6_TRACE_EN
    always @(posedge clock) begin
        if (reset && state == FETCH) $display("PC=%h OP=%h", pc, data_in);
    end
`else
`endif

endmodule

// File: tb/tb_cpu6.sv
// Self-checking bench for cpu6: runs small ROM programs against a byte memory model
// and compares bus writes, fetch addresses and interrupt level against expectations.
module tb_cpu6;

    logic        clock, reset, int_reqn;
    logic [7:0]  data_in, data_out;
    logic [3:0]  irq_number;
    logic        write_en;
    logic [18:0] address;

    logic [7:0]  mem [0:524287];
    logic [7:0]  prog [$];
    logic [26:0] exp_wr [$];
    logic [26:0] obs_wr [$];
    logic [18:0] addr_log [$];
    logic [3:0]  irq_log [$];
    int          stray;
    int          checks = 0;
    int          errors = 0;

    assign data_in = mem[address];

    cpu6 dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .int_reqn   (int_reqn),
        .irq_number (irq_number),
        .write_en   (write_en),
        .address    (address),
        .data_out   (data_out)
    );

    initial begin
        clock = 1'b0;
        forever #50 clock = ~clock;
    end

    task hold_reset();
        reset    = 1'b0;
        int_reqn = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 524288; i++) mem[i] = 8'h00;
        exp_wr.delete();
        obs_wr.delete();
        addr_log.delete();
        irq_log.delete();
        stray = 0;
    endtask

    task load_prog(input logic [18:0] base);
        for (int i = 0; i < prog.size(); i++) mem[base + 19'(i)] = prog[i];
    endtask

    task sample();
        addr_log.push_back(address);
        irq_log.push_back(irq_number);
        if (write_en) begin
            obs_wr.push_back({address, data_out});
            mem[address] = data_out;
        end else if (data_out !== 8'h00) begin
            stray++;
        end
    endtask

    task release_reset();
        @(negedge clock);
        reset = 1'b1;
        #1 sample();
    endtask

    task run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            sample();
        end
    endtask

    task test_reset();
        logic [26:0] e, g;
        hold_reset();
        checks++; if (address !== 19'h3FD00) begin errors++; $display("[TB] FAIL reset_address: got %h expected 3fd00", address); end
        checks++; if (write_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_write_en: got %b expected 0", write_en); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_out: got %h expected 00", data_out); end
        checks++; if (irq_number !== 4'd0) begin errors++; $display("[TB] FAIL reset_irq: got %0d expected 0", irq_number); end
        prog = '{8'h71, 8'h80, 8'h01};
        load_prog(19'h3FD00);
        release_reset();
        run_cycles(5);
        checks++; if (addr_log[0] !== 19'h3FD00) begin errors++; $display("[TB] FAIL first_fetch: got %h expected 3fd00", addr_log[0]); end
        checks++; if (addr_log[4] !== 19'h08001) begin errors++; $display("[TB] FAIL jmp_target: got %h expected 08001", addr_log[4]); end
        checks++; if (obs_wr.size() != 0) begin errors++; $display("[TB] FAIL jmp_no_write: got %0d writes expected 0", obs_wr.size()); end
        e = 0; g = 0;
    endtask

    task test_store();
        logic [26:0] e, g;
        hold_reset();
        prog = '{8'h80, 8'h48, 8'hA1, 8'hF2, 8'h01, 8'h00};
        load_prog(19'h3FD00);
        exp_wr.push_back({19'h3F201, 8'h48});
        release_reset();
        run_cycles(12);
        checks++; if (addr_log[6] !== 19'h3F201) begin errors++; $display("[TB] FAIL stal_cycle7_addr: got %h expected 3f201", addr_log[6]); end
        checks++; if (addr_log[8] !== 19'h3FD05) begin errors++; $display("[TB] FAIL stal_next_fetch: got %h expected 3fd05", addr_log[8]); end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (obs_wr.size() == 0) begin errors++; $display("[TB] FAIL stal_write: got none expected %h", e); end
            else begin g = obs_wr.pop_front(); if (g !== e) begin errors++; $display("[TB] FAIL stal_write: got %h expected %h", g, e); end end
        end
        checks++; if (obs_wr.size() != 0 || stray != 0) begin errors++; $display("[TB] FAIL stal_extra: got %0d extra writes, %0d stray data, expected 0", obs_wr.size(), stray); end
    endtask

    task test_branch();
        hold_reset();
        prog = '{8'h22, 8'h10, 8'h14, 8'h02, 8'h00, 8'h00, 8'h01, 8'h00};
        load_prog(19'h3FD00);
        release_reset();
        run_cycles(8);
        checks++; if (addr_log[6] !== 19'h3FD06) begin errors++; $display("[TB] FAIL bz_taken: got %h expected 3fd06", addr_log[6]); end
        hold_reset();
        prog = '{8'h80, 8'h05, 8'h14, 8'h02, 8'h01, 8'h00, 8'h00};
        load_prog(19'h3FD00);
        release_reset();
        run_cycles(8);
        checks++; if (addr_log[6] !== 19'h3FD04) begin errors++; $display("[TB] FAIL bz_not_taken: got %h expected 3fd04", addr_log[6]); end
    endtask

    task test_aabw();
        logic [26:0] e, g;
        hold_reset();
        prog = '{8'hC0, 8'h01, 8'h90, 8'hFF, 8'hFF, 8'h58, 8'hB1, 8'hF0, 8'h00,
                 8'h14, 8'h01, 8'h00, 8'h01, 8'h00};
        load_prog(19'h3FD00);
        exp_wr.push_back({19'h3F000, 8'h00});
        exp_wr.push_back({19'h3F001, 8'h00});
        release_reset();
        run_cycles(24);
        checks++; if (addr_log[18] !== 19'h3FD0C) begin errors++; $display("[TB] FAIL aabw_zero_branch: got %h expected 3fd0c", addr_log[18]); end
        checks++; if (dut.flag_c !== 1'b1) begin errors++; $display("[TB] FAIL aabw_carry: got %b expected 1", dut.flag_c); end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (obs_wr.size() == 0) begin errors++; $display("[TB] FAIL aabw_write: got none expected %h", e); end
            else begin g = obs_wr.pop_front(); if (g !== e) begin errors++; $display("[TB] FAIL aabw_write: got %h expected %h", g, e); end end
        end
        checks++; if (obs_wr.size() != 0) begin errors++; $display("[TB] FAIL aabw_extra: got %0d extra writes expected 0", obs_wr.size()); end
    endtask

    task test_alu();
        logic [26:0] e, g;
        hold_reset();
        prog = '{8'h90, 8'h12, 8'h34, 8'hC0, 8'hF0, 8'h42, 8'h31, 8'h49, 8'h3D,
                 8'h40, 8'h10, 8'hB1, 8'hF0, 8'h10, 8'h3A, 8'hB1, 8'hF0, 8'h30,
                 8'h91, 8'hF0, 8'h10, 8'hA1, 8'hF0, 8'h20, 8'h5F, 8'h00};
        load_prog(19'h3FD00);
        exp_wr.push_back({19'h3F010, 8'hA4});
        exp_wr.push_back({19'h3F011, 8'h80});
        exp_wr.push_back({19'h3F030, 8'h00});
        exp_wr.push_back({19'h3F031, 8'h00});
        exp_wr.push_back({19'h3F020, 8'h80});
        release_reset();
        run_cycles(70);
        checks++; if (dut.flag_c !== 1'b0) begin errors++; $display("[TB] FAIL alu_carry: got %b expected 0", dut.flag_c); end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (obs_wr.size() == 0) begin errors++; $display("[TB] FAIL alu_write: got none expected %h", e); end
            else begin g = obs_wr.pop_front(); if (g !== e) begin errors++; $display("[TB] FAIL alu_write: got %h expected %h", g, e); end end
        end
        checks++; if (obs_wr.size() != 0 || stray != 0) begin errors++; $display("[TB] FAIL alu_extra: got %0d extra writes, %0d stray data, expected 0", obs_wr.size(), stray); end
    endtask

    task test_halt();
        logic [26:0] e, g;
        int changes, irqs;
        hold_reset();
        prog = '{8'h04, 8'h80, 8'h01, 8'hA1, 8'hF9, 8'h00, 8'h00};
        load_prog(19'h3FD00);
        mem[19'h00100] = 8'h01;
        exp_wr.push_back({19'h3F900, 8'h01});
        release_reset();
        run_cycles(12);
        int_reqn = 1'b0;
        run_cycles(20);
        int_reqn = 1'b1;
        checks++; if (addr_log[10] !== 19'h3FD06) begin errors++; $display("[TB] FAIL hlt_fetch: got %h expected 3fd06", addr_log[10]); end
        changes = 0;
        irqs = 0;
        for (int i = 13; i < addr_log.size(); i++) if (addr_log[i] !== addr_log[i-1]) changes++;
        for (int i = 0; i < irq_log.size(); i++) if (irq_log[i] !== 4'd0) irqs++;
        checks++; if (changes != 0) begin errors++; $display("[TB] FAIL halt_frozen: got %0d address changes expected 0", changes); end
        checks++; if (irqs != 0) begin errors++; $display("[TB] FAIL halt_irq_ignored: got %0d cycles in interrupt expected 0", irqs); end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (obs_wr.size() == 0) begin errors++; $display("[TB] FAIL halt_write: got none expected %h", e); end
            else begin g = obs_wr.pop_front(); if (g !== e) begin errors++; $display("[TB] FAIL halt_write: got %h expected %h", g, e); end end
        end
        checks++; if (obs_wr.size() != 0) begin errors++; $display("[TB] FAIL halt_extra: got %0d writes after halt expected 0", obs_wr.size()); end
    endtask

    task test_interrupt();
        hold_reset();
        prog = '{8'h04, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
        load_prog(19'h3FD00);
        mem[19'h00100] = 8'h0A;
        release_reset();
        run_cycles(2);
        int_reqn = 1'b0;
        run_cycles(2);
        int_reqn = 1'b1;
        run_cycles(4);
        checks++; if (addr_log[2] !== 19'h3FD01 || irq_log[2] !== 4'd0) begin errors++; $display("[TB] FAIL irq_before: got %h/%0d expected 3fd01/0", addr_log[2], irq_log[2]); end
        checks++; if (addr_log[4] !== 19'h00100) begin errors++; $display("[TB] FAIL irq_vector: got %h expected 00100", addr_log[4]); end
        checks++; if (irq_log[4] !== 4'd1) begin errors++; $display("[TB] FAIL irq_level: got %0d expected 1", irq_log[4]); end
        checks++; if (addr_log[6] !== 19'h3FD02) begin errors++; $display("[TB] FAIL reti_resume: got %h expected 3fd02", addr_log[6]); end
        checks++; if (irq_log[6] !== 4'd0) begin errors++; $display("[TB] FAIL reti_level: got %0d expected 0", irq_log[6]); end
    endtask

    task test_reset_abort();
        hold_reset();
        prog = '{8'h90, 8'hAB, 8'hCD, 8'hB1, 8'hF3, 8'h00, 8'h00};
        load_prog(19'h3FD00);
        release_reset();
        run_cycles(6);
        @(posedge clock);
        #5;
        checks++; if (write_en !== 1'b1 || address !== 19'h3F300 || data_out !== 8'hAB) begin errors++; $display("[TB] FAIL abort_pre_write: got %b %h %h expected 1 3f300 ab", write_en, address, data_out); end
        reset = 1'b0;
        #1;
        checks++; if (write_en !== 1'b0) begin errors++; $display("[TB] FAIL abort_write_en: got %b expected 0", write_en); end
        checks++; if (address !== 19'h3FD00 || data_out !== 8'h00) begin errors++; $display("[TB] FAIL abort_bus: got %h %h expected 3fd00 00", address, data_out); end
        run_cycles(3);
        checks++; if (obs_wr.size() != 0 || mem[19'h3F300] !== 8'h00) begin errors++; $display("[TB] FAIL abort_no_write: got %0d writes expected 0", obs_wr.size()); end
    endtask

    initial begin
        reset    = 1'b0;
        int_reqn = 1'b1;
        test_reset();
        test_store();
        test_branch();
        test_aabw();
        test_alu();
        test_halt();
        test_interrupt();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
